led_mode_controller: RTL and testbench

Sequencer for the board's six active-low LEDs. It owns a prescaler that generates a periodic step tick, a button input conditioner, and a four-mode pattern state machine. It sits between the 27 MHz system clock and the LED pins, replacing a free-running LED counter with user-selectable patterns. A single push-button cycles the active mode.

---
 rtl/led_mode_controller.sv | 188 ++++++++++++++++++
 tb/tb_led_mode_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_controller.sv
// rtl/led_mode_controller.sv - six-LED pattern sequencer: step prescaler, push-button conditioner, four-mode pattern FSM
// Build option: define LED_MODE_DEBOUNCE_EN to include the button debounce counter.
module led_mode_controller #(
    parameter int TICK_DIV        = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic [5:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    // Both divisors need at least two states for the counters to make sense.
    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("led_mode_controller: TICK_DIV and DEBOUNCE_CYCLES must be at least 2");
    end

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [5:0] PAT_COUNT_INIT  = 6'b000000;
    localparam logic [5:0] PAT_SHIFT_INIT  = 6'b000001;
    localparam logic [5:0] PAT_BOUNCE_INIT = 6'b000001;
    localparam logic [5:0] PAT_BLINK_INIT  = 6'b111111;
    localparam logic [5:0] PAT_TOP         = 6'b100000;
    localparam logic [5:0] PAT_BOTTOM      = 6'b000001;

    typedef enum logic [1:0] {
        M_COUNT  = 2'd0,
        M_SHIFT  = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    // Mode order on each button press.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            M_COUNT:  return M_SHIFT;
            M_SHIFT:  return M_BOUNCE;
            M_BOUNCE: return M_BLINK;
            default:  return M_COUNT;
        endcase
    endfunction

    // Pattern loaded when a mode is entered.
    function automatic logic [5:0] init_pat(input mode_t m);
        case (m)
            M_COUNT:  return PAT_COUNT_INIT;
            M_SHIFT:  return PAT_SHIFT_INIT;
            M_BOUNCE: return PAT_BOUNCE_INIT;
            default:  return PAT_BLINK_INIT;
        endcase
    endfunction

    logic [TW-1:0] tick_cnt;
    logic          sync_meta;
    logic          sync_q;
    logic          btn_stable;
    logic          btn_stable_q;
    logic          press;
    mode_t         state;
    logic [5:0]    pat;
    logic          dir_right;
    logic [5:0]    bounce_left;
    logic [5:0]    bounce_right;

    // ------------------------------------------------------------------
    // Prescaler: tick is a decode of the counter's last state, so it is
    // high for exactly one cycle per TICK_DIV and needs no extra flop.
    // ------------------------------------------------------------------
    assign tick = (tick_cnt == TICK_LAST);

    // Free-running step counter; a press restarts the step interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (press || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button conditioning. btn_n is asynchronous, so it crosses two flops
    // before any logic looks at it. Idle (released) level is 1.
    // ------------------------------------------------------------------

    // Two-flop synchronizer, idle-high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= btn_n;
            sync_q    <= sync_meta;
        end
    end

`ifdef LED_MODE_DEBOUNCE_EN
    localparam int            DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt;

    // Accept a new level only after it has differed from the current one
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt     <= '0;
            btn_stable <= 1'b1;
        end else if (sync_q == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            btn_stable <= sync_q;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    // Without debounce every synchronized level change is taken as-is.
    assign btn_stable = sync_q;
`endif

    // Previous conditioned level, for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_stable_q <= 1'b1;
        end else begin
            btn_stable_q <= btn_stable;
        end
    end

    // A press is the 1->0 transition of the conditioned level; releases are ignored.
    assign press = btn_stable_q & ~btn_stable;

    // ------------------------------------------------------------------
    // Pattern generation
    // ------------------------------------------------------------------
    assign bounce_left  = {pat[4:0], 1'b0};
    assign bounce_right = {1'b0, pat[5:1]};

    // Mode FSM and pattern register; a press outranks a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= M_COUNT;
            pat       <= PAT_COUNT_INIT;
            dir_right <= 1'b0;
        end else if (press) begin
            state     <= next_mode(state);
            pat       <= init_pat(next_mode(state));
            dir_right <= 1'b0;
        end else if (tick) begin
            case (state)
                M_COUNT: begin
                    pat <= pat + 6'd1;
                end
                M_SHIFT: begin
                    pat <= {pat[4:0], pat[5]};
                end
                M_BOUNCE: begin
                    // Direction flips on the step that lands on an end.
                    if (!dir_right) begin
                        pat <= bounce_left;
                        if (bounce_left == PAT_TOP) begin
                            dir_right <= 1'b1;
                        end
                    end else begin
                        pat <= bounce_right;
                        if (bounce_right == PAT_BOTTOM) begin
                            dir_right <= 1'b0;
                        end
                    end
                end
                default: begin
                    pat <= ~pat;
                end
            endcase
        end
    end

    assign mode = state;
    assign led  = ~pat;

endmodule

// File: tb/tb_led_mode_controller.sv
// tb/tb_led_mode_controller.sv - self-checking bench for led_mode_controller (TICK_DIV=4, DEBOUNCE_CYCLES=8)
module tb_led_mode_controller;

    localparam int TD = 4;
    localparam int DB = 8;
`ifdef LED_MODE_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // Edges from the first low sample of btn_n to the mode change.
    localparam int LAT = DB_EN ? DB + 3 : 3;
    // High cycles that guarantee a release has been accepted.
    localparam int RLS = LAT + 1;
    // Idle cycles so that a following press cycle lands on a tick cycle.
    localparam int OFF = (TD - ((LAT - 1) % TD)) % TD;
    localparam int MID = DB_EN ? 5 : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic [5:0] led;
    logic [1:0] mode;
    logic       tick;

    led_mode_controller #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .led   (led),
        .mode  (mode),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: button history, accepted level, pending press,
    // current mode, steps taken in this mode and cycles since the last restart.
    bit m_s1 = 1'b1, m_s2 = 1'b1, m_stable = 1'b1, m_press = 1'b0;
    int m_run = 0, m_mode = 0, m_k = 0, m_cyc = 0;

    // Pattern after k steps in a mode, computed directly from the step count.
    function automatic logic [5:0] pat_of(input int md, input int k);
        int p;
        int idx;
        case (md)
            0: return 6'(k % 64);
            1: return 6'(1 << (k % 6));
            2: begin
                p   = k % 10;
                idx = (p <= 5) ? p : 10 - p;
                return 6'(1 << idx);
            end
            default: return ((k % 2) == 0) ? 6'b111111 : 6'b000000;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic b);
        bit was;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_press = 1'b0;
            m_run = 0; m_mode = 0; m_k = 0; m_cyc = 0;
            return;
        end
        if (m_press) begin
            m_mode = (m_mode + 1) % 4;
            m_k    = 0;
            m_cyc  = 0;
        end else begin
            if (m_cyc % TD == TD - 1) m_k++;
            m_cyc++;
        end
        was = m_stable;
        if (DB_EN) begin
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DB) begin
                    m_stable = m_s2;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        if (!DB_EN) m_stable = m_s2;
        m_press = was && !m_stable;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic cycle(input logic r, input logic b);
        logic [8:0] want;
        rst   = r;
        btn_n = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        want = {2'(m_mode), ~pat_of(m_mode, m_k), (m_cyc % TD == TD - 1)};
        nvec++;
        if ({mode, led, tick} !== want) begin
            nerr++;
            $display("FAIL model @%0t: got mode=%0d led=%b tick=%b, want mode=%0d led=%b tick=%b",
                     $time, mode, led, tick, want[8:7], want[6:1], want[0]);
        end
    endtask

    task automatic release_btn();
        repeat (RLS) cycle(1'b0, 1'b1);
    endtask

    task automatic press_once(input int want_mode);
        int n;
        n = 0;
        while (int'(mode) != want_mode && n < 3 * LAT) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        chk($sformatf("press_to_mode%0d", want_mode), 32'(mode), 32'(want_mode));
    endtask

    typedef struct {
        logic       rst;
        logic       btn_n;
        logic [1:0] mode;
        logic [5:0] led;
        logic       tick;
    } vec_t;

    vec_t       vt[21];
    logic [5:0] bled[10];

    initial begin
        int         changes;
        int         n;
        logic [1:0] prev;
        logic       seen;
        int         lvl;
        int         len;
        int         done;

        // Reset, then 20 free-running cycles in COUNT.
        vt[0]  = '{1'b1, 1'b1, 2'd0, 6'b111111, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 2'd0, 6'b111111, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 2'd0, 6'b111111, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 2'd0, 6'b111111, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 2'd0, 6'b111110, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 2'd0, 6'b111110, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 2'd0, 6'b111110, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 2'd0, 6'b111110, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 2'd0, 6'b111101, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 2'd0, 6'b111101, 1'b0};
        vt[10] = '{1'b0, 1'b1, 2'd0, 6'b111101, 1'b0};
        vt[11] = '{1'b0, 1'b1, 2'd0, 6'b111101, 1'b1};
        vt[12] = '{1'b0, 1'b1, 2'd0, 6'b111100, 1'b0};
        vt[13] = '{1'b0, 1'b1, 2'd0, 6'b111100, 1'b0};
        vt[14] = '{1'b0, 1'b1, 2'd0, 6'b111100, 1'b0};
        vt[15] = '{1'b0, 1'b1, 2'd0, 6'b111100, 1'b1};
        vt[16] = '{1'b0, 1'b1, 2'd0, 6'b111011, 1'b0};
        vt[17] = '{1'b0, 1'b1, 2'd0, 6'b111011, 1'b0};
        vt[18] = '{1'b0, 1'b1, 2'd0, 6'b111011, 1'b0};
        vt[19] = '{1'b0, 1'b1, 2'd0, 6'b111011, 1'b1};
        vt[20] = '{1'b0, 1'b1, 2'd0, 6'b111010, 1'b0};

        // BOUNCE steps 1..10 as seen on the active-low led pins.
        bled[0] = 6'b111101; bled[1] = 6'b111011; bled[2] = 6'b110111; bled[3] = 6'b101111;
        bled[4] = 6'b011111; bled[5] = 6'b101111; bled[6] = 6'b110111; bled[7] = 6'b111011;
        bled[8] = 6'b111101; bled[9] = 6'b111110;

        for (int i = 0; i < 21; i++) begin
            cycle(vt[i].rst, vt[i].btn_n);
            chk($sformatf("table%0d_mode", i), 32'(mode), 32'(vt[i].mode));
            chk($sformatf("table%0d_led", i),  32'(led),  32'(vt[i].led));
            chk($sformatf("table%0d_tick", i), 32'(tick), 32'(vt[i].tick));
        end

        // Held button: exactly one press, at the expected edge; SHIFT wraps after 6 steps.
        cycle(1'b1, 1'b1);
        for (int j = 1; j <= LAT + 48; j++) begin
            cycle(1'b0, (j <= 20) ? 1'b0 : 1'b1);
            chk("hold_mode", 32'(mode), (j >= LAT) ? 32'd1 : 32'd0);
            if (j == LAT)      chk("hold_first_led", 32'(led), 32'b111110);
            if (j == LAT + 47) chk("hold_led_top", 32'(led), 32'b011111);
            if (j == LAT + 48) chk("hold_led_wrapped", 32'(led), 32'b111110);
        end

        // Short bounces: rejected with debounce, each one a press without.
        cycle(1'b1, 1'b1);
        changes = 0;
        prev    = mode;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 10; j++) begin
                cycle(1'b0, (j < 5) ? 1'b0 : 1'b1);
                if (mode != prev) changes++;
                prev = mode;
            end
        end
        chk("glitch_mode_changes", 32'(changes), DB_EN ? 32'd0 : 32'd4);
        repeat (12) cycle(1'b0, 1'b0);
        chk("glitch_then_hold_mode", 32'(mode), 32'd1);

        // BOUNCE: one full 10-step period after entry.
        release_btn();
        press_once(2);
        chk("bounce_init_led", 32'(led), 32'b111110);
        for (int i = 0; i < 10; i++) begin
            seen = 1'b0;
            n    = 0;
            while (!seen && n < 2 * TD) begin
                seen = tick;
                cycle(1'b0, 1'b1);
                n++;
            end
            chk("bounce_tick_found", 32'(seen), 32'd1);
            chk($sformatf("bounce_step%0d", i + 1), 32'(led), 32'(bled[i]));
        end

        // BLINK: press lands on a tick cycle; press wins and the prescaler restarts.
        press_once(3);
        chk("blink_init_led", 32'(led), 32'b000000);
        release_btn();
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 2 * TD) begin
            cycle(1'b0, 1'b1);
            seen = tick;
            n++;
        end
        chk("align_tick_found", 32'(seen), 32'd1);
        repeat (OFF) cycle(1'b0, 1'b1);
        repeat (LAT - 1) cycle(1'b0, 1'b0);
        chk("align_tick_with_press", 32'(tick), 32'd1);
        chk("align_mode_before", 32'(mode), 32'd3);
        cycle(1'b0, 1'b0);
        chk("align_mode_after", 32'(mode), 32'd0);
        chk("align_led_after", 32'(led), 32'b111111);
        chk("align_tick_after", 32'(tick), 32'd0);
        cycle(1'b0, 1'b1);
        chk("align_gap1_tick", 32'(tick), 32'd0);
        cycle(1'b0, 1'b1);
        chk("align_gap2_tick", 32'(tick), 32'd0);
        cycle(1'b0, 1'b1);
        chk("align_next_tick", 32'(tick), 32'd1);

        // Reset mid-debounce in BOUNCE with pat=001000, button still low.
        release_btn();
        press_once(1);
        release_btn();
        press_once(2);
        release_btn();
        n = 0;
        while (led !== 6'b110111 && n < 40) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("midreset_pat_found", 32'(led), 32'b110111);
        repeat (MID) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("midreset_mode", 32'(mode), 32'd0);
        chk("midreset_led", 32'(led), 32'b111111);
        chk("midreset_tick", 32'(tick), 32'd0);
        for (int j = 1; j <= LAT + 2; j++) begin
            cycle(1'b0, 1'b0);
            chk("post_reset_press_latency", 32'(mode), (j >= LAT) ? 32'd1 : 32'd0);
        end

        // Random button activity with occasional resets against the model.
        cycle(1'b1, 1'b1);
        done = 0;
        while (done < 3000) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 2 * DB + 6);
            for (int j = 0; j < len; j++) begin
                cycle(($urandom_range(0, 399) == 0), lvl[0]);
                done++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", nvec);
        $fatal(1);
    end

endmodule
